// File: rtl/alu_control_mc.sv
// ALU control unit: combinational decode for single-cycle ops, counter FSM for iterative ops.
// Optional divide support is enabled by defining ALU_CTRL_DIV_EN.
module alu_control_mc #(
  parameter int unsigned CTRL_W  = 3,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [5:0]        funct_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              illegal_o
);

  if ((CTRL_W < 3) || (MUL_LAT < 1) || (DIV_LAT < 1)) begin : gen_param_check
    $error("alu_control_mc: CTRL_W must be >= 3, MUL_LAT and DIV_LAT must be >= 1");
  end

`ifdef ALU_CTRL_DIV_EN
  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
`else
  localparam int unsigned MaxLat = MUL_LAT;
`endif
  localparam int unsigned CntW = $clog2(MaxLat + 1);

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpMul = 3'b011;
`ifdef ALU_CTRL_DIV_EN
  localparam logic [2:0] OpDiv = 3'b100;
`endif
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;

  logic [2:0]      dec_code;
  logic            dec_iter;
  logic            dec_ill;
  logic [CntW-1:0] dec_cnt;

  // Instruction decode; dec_cnt is the remaining-cycle count loaded on issue.
  always_comb begin
    dec_code = OpAdd;
    dec_iter = 1'b0;
    dec_ill  = 1'b0;
    dec_cnt  = '0;
    unique case (ALUOp_i)
      2'b00: dec_code = OpAdd;
      2'b01: dec_code = OpSub;
      2'b10: dec_code = OpOr;
      default: begin
        case (funct_i)
          6'b100000: dec_code = OpAdd;
          6'b100010: dec_code = OpSub;
          6'b100100: dec_code = OpAnd;
          6'b100101: dec_code = OpOr;
          6'b101010: dec_code = OpSlt;
          6'b011000: begin
            dec_code = OpMul;
            dec_iter = 1'b1;
            dec_cnt  = CntW'(MUL_LAT - 1);
          end
`ifdef ALU_CTRL_DIV_EN
          6'b011010: begin
            dec_code = OpDiv;
            dec_iter = 1'b1;
            dec_cnt  = CntW'(DIV_LAT - 1);
          end
`endif
          default: dec_ill = 1'b1;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      StIdle: begin
        if (valid_i && dec_iter) begin
          state_d = StBusy;
          cnt_d   = dec_cnt;
          op_d    = dec_code;
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset forces benign outputs combinationally so a held-in-reset pipeline never stalls.
  always_comb begin
    ALUCtrl_o = CTRL_W'(OpAdd);
    busy_o    = 1'b0;
    done_o    = 1'b0;
    illegal_o = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        StIdle: begin
          ALUCtrl_o = CTRL_W'(dec_code);
          busy_o    = valid_i && dec_iter;
          illegal_o = dec_ill;
        end
        StBusy: begin
          ALUCtrl_o = CTRL_W'(op_q);
          busy_o    = (cnt_q != '0);
          done_o    = (cnt_q == '0);
        end
        default: ;
      endcase
    end
  end

endmodule
